// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch-stage program-counter unit.
//   XLEN_DEF          default address width
//   XLEN_MAX          widest address the BTB entry struct can carry
//   RESET_VECTOR_DEF  default first fetch address after reset
//   next_sel_e        which source feeds the next PC
//   btb_entry_t       one BTB line {valid, tag, target}
// ----------------------------------------------------------------------------
package pc_pkg;

    localparam int              XLEN_DEF         = 32;
    localparam int              XLEN_MAX         = 64;
    localparam logic [XLEN_DEF-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

    // Ordered from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_REDIRECT = 3'd0,
        SEL_PENDING  = 3'd1,
        SEL_HOLD     = 3'd2,
        SEL_PRED     = 3'd3,
        SEL_SEQ      = 3'd4
    } next_sel_e;

    // Fields are sized for the widest supported address; narrower
    // configurations zero-extend into them.
    typedef struct packed {
        logic                valid;
        logic [XLEN_MAX-1:0] tag;
        logic [XLEN_MAX-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/pc_unit_branch_target_buffer.sv
// ----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB: combinational lookup on the fetch PC, update at the
// clock edge from the EX-stage branch resolution.
// Ports:
//   CLOCK, RESET           clock, asynchronous active-high reset (clears valid)
//   PC                     fetch address to look up
//   HIT, TARGET            lookup result (TARGET is word aligned)
//   BR_RESOLVE             a branch/jump resolved this cycle
//   BR_PC, BR_TARGET       its address and computed target
//   BR_TAKEN               its resolved direction
// ----------------------------------------------------------------------------
module branch_target_buffer
    import pc_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic [XLEN-1:0] PC,
    output logic            HIT,
    output logic [XLEN-1:0] TARGET,
    input  logic            BR_RESOLVE,
    input  logic [XLEN-1:0] BR_PC,
    input  logic [XLEN-1:0] BR_TARGET,
    input  logic            BR_TAKEN
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]       tag_reg    [BTB_ENTRIES];
    logic [XLEN-3:0]        target_reg [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    btb_entry_t       rd_entry;

    assign rd_idx = PC[IDX_W+1:2];
    assign rd_tag = PC[XLEN-1:IDX_W+2];
    assign wr_idx = BR_PC[IDX_W+1:2];
    assign wr_tag = BR_PC[XLEN-1:IDX_W+2];

    // Lookup reads the registered contents, so a same-cycle update is only
    // visible from the following cycle.
    always_comb begin
        rd_entry        = '0;
        rd_entry.valid  = valid_reg[rd_idx];
        rd_entry.tag    = XLEN_MAX'(tag_reg[rd_idx]);
        rd_entry.target = XLEN_MAX'({target_reg[rd_idx], 2'b00});
    end

    assign HIT    = rd_entry.valid && (rd_entry.tag == XLEN_MAX'(rd_tag));
    assign TARGET = XLEN'(rd_entry.target);

    assign wr_hit = valid_reg[wr_idx] && (tag_reg[wr_idx] == wr_tag);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            valid_reg <= '0;
        end else if (BR_RESOLVE) begin
            if (BR_TAKEN) begin
                valid_reg[wr_idx] <= 1'b1;
            end else if (wr_hit) begin
                // Only unlearn the branch that owns the line, not an alias.
                valid_reg[wr_idx] <= 1'b0;
            end
        end
    end

    // Tag/target need no reset: they are never used while valid is 0.
    always_ff @(posedge CLOCK) begin
        if (BR_RESOLVE && BR_TAKEN) begin
            tag_reg[wr_idx]    <= wr_tag;
            target_reg[wr_idx] <= BR_TARGET[XLEN-1:2];
        end
    end

    logic unused_lsbs;
    assign unused_lsbs = ^{PC[1:0], BR_PC[1:0], BR_TARGET[1:0]};

endmodule

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit
// Fetch-stage program counter with next-PC priority mux, a redirect-capture
// latch for redirects that arrive during an instruction-memory wait, and an
// optional direct-mapped BTB for zero-bubble taken branches.
// Ports:
//   CLOCK, RESET               clock, asynchronous active-high reset
//   BUSYWAIT                   imem not ready: PC holds, redirects are latched
//   STALL                      load-use stall: PC holds (redirect overrides)
//   REDIRECT_EN, REDIRECT_PC   EX-stage correction
//   BR_RESOLVE, BR_PC,
//   BR_TARGET, BR_TAKEN        branch resolution feeding the BTB
//   PC, PC_PLUS4               current fetch address and its successor
//   PRED_TAKEN                 BTB hit on PC
//   FETCH_VALID                0 while a latched redirect makes the fetch stale
// ----------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int              BTB_ENTRIES  = 16,
    parameter bit              BTB_EN       = 1'b1
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            BUSYWAIT,
    input  logic            STALL,
    input  logic            REDIRECT_EN,
    input  logic [XLEN-1:0] REDIRECT_PC,
    input  logic            BR_RESOLVE,
    input  logic [XLEN-1:0] BR_PC,
    input  logic [XLEN-1:0] BR_TARGET,
    input  logic            BR_TAKEN,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_PLUS4,
    output logic            PRED_TAKEN,
    output logic            FETCH_VALID
);

    localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic            pending_reg;
    logic            pending_next;
    logic [XLEN-1:0] pending_pc_reg;
    logic [XLEN-1:0] pending_pc_next;
    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] pc_plus4;
    logic            pred_hit;
    logic [XLEN-1:0] pred_target;
    next_sel_e       next_sel;

    assign redirect_aligned = {REDIRECT_PC[XLEN-1:2], 2'b00};
    assign pc_plus4         = pc_reg + XLEN'(4);

    // ------------------------------------------------------------------
    // Optional BTB
    // ------------------------------------------------------------------
    generate
        if (BTB_EN) begin : g_btb
            branch_target_buffer #(
                .XLEN        (XLEN),
                .BTB_ENTRIES (BTB_ENTRIES)
            ) u_btb (
                .CLOCK      (CLOCK),
                .RESET      (RESET),
                .PC         (pc_reg),
                .HIT        (pred_hit),
                .TARGET     (pred_target),
                .BR_RESOLVE (BR_RESOLVE),
                .BR_PC      (BR_PC),
                .BR_TARGET  (BR_TARGET),
                .BR_TAKEN   (BR_TAKEN)
            );
        end else begin : g_no_btb
            assign pred_hit    = 1'b0;
            assign pred_target = '0;
            logic unused_br;
            assign unused_br = ^{BR_RESOLVE, BR_PC, BR_TARGET, BR_TAKEN};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-PC source select
    // ------------------------------------------------------------------
    always_comb begin
        next_sel = SEL_SEQ;
        if (REDIRECT_EN) begin
            next_sel = SEL_REDIRECT;
        end else if (pending_reg) begin
            next_sel = SEL_PENDING;
        end else if (STALL) begin
            next_sel = SEL_HOLD;
        end else if (pred_hit) begin
            next_sel = SEL_PRED;
        end
    end

    always_comb begin
        pc_next         = pc_reg;
        pending_next    = pending_reg;
        pending_pc_next = pending_pc_reg;
        if (BUSYWAIT) begin
            // The fetch in flight cannot be abandoned; remember the newest
            // redirect and apply it once memory responds.
            if (REDIRECT_EN) begin
                pending_next    = 1'b1;
                pending_pc_next = redirect_aligned;
            end
        end else begin
            // A fresh redirect supersedes any latched one, so the latch is
            // consumed on every non-waiting edge.
            pending_next = 1'b0;
            unique case (next_sel)
                SEL_REDIRECT: pc_next = redirect_aligned;
                SEL_PENDING:  pc_next = pending_pc_reg;
                SEL_HOLD:     pc_next = pc_reg;
                SEL_PRED:     pc_next = pred_target;
                default:      pc_next = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pc_reg         <= RESET_PC;
            pending_reg    <= 1'b0;
            pending_pc_reg <= '0;
        end else begin
            pc_reg         <= pc_next;
            pending_reg    <= pending_next;
            pending_pc_reg <= pending_pc_next;
        end
    end

    assign PC          = pc_reg;
    assign PC_PLUS4    = pc_plus4;
    assign PRED_TAKEN  = pred_hit;
    assign FETCH_VALID = ~pending_reg;

    logic unused_lsbs;
    assign unused_lsbs = ^{REDIRECT_PC[1:0]};

endmodule
